// File: rtl/rand_byte_checker_pkg.sv
// Shared types and constants for the rand_byte_checker slice: FSM states,
// model tap byte and counter widths.
package rand_byte_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FAIL = 2'd2
  } chk_state_t;

  localparam logic [7:0] TAP_BYTE   = 8'hA3;
  localparam int         ERR_CNT_W  = 16;
  localparam int         BYTE_CNT_W = 32;
  localparam int         CONSEC_W   = 8;

endpackage

// File: rtl/rand_byte_model.sv
// Expected-sequence model: RW-bit shift register with the tap byte replicated
// across the word; loads a seed and steps once per enable.
module rand_byte_model
  import rand_byte_checker_pkg::*;
#(
  parameter int RW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [RW-1:0] seed,
  input  logic          step,
  output logic [7:0]    exp_byte
);

  localparam logic [RW-1:0] TAP_MASK = {(RW/8){TAP_BYTE}};

  logic [RW-1:0] state_p1;
  logic [RW-1:0] state_nxt;

  always_comb begin
    state_nxt    = '0;
    state_nxt[0] = state_p1[RW-1];
    for (int i = 1; i < RW; i++) begin
      state_nxt[i] = TAP_MASK[i] ? (state_p1[i-1] ^ state_p1[RW-1]) : state_p1[i-1];
    end
  end

  // stage p1: model register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1 <= '0;
    end else if (load) begin
      state_p1 <= seed;
    end else if (step) begin
      state_p1 <= state_nxt;
    end
  end

  assign exp_byte = state_p1[7:0];

endmodule

// File: rtl/rand_byte_checker.sv
// Received-byte checker against a seeded pseudo-random model.
// Optional first-mismatch capture ports: define RAND_CHK_ERR_CAPTURE_EN.
module rand_byte_checker
  import rand_byte_checker_pkg::*;
#(
  parameter int RW        = 32,
  parameter int ERR_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [RW-1:0] i_seed,
  input  logic          i_valid,
  input  logic [7:0]    i_byte,
  output logic          o_err,
  output logic [15:0]   o_err_cnt,
  output logic [31:0]   o_byte_cnt,
  output logic          o_fail,
  output logic          o_running
`ifdef RAND_CHK_ERR_CAPTURE_EN
  ,
  output logic          o_cap_valid,
  output logic [31:0]   o_cap_idx,
  output logic [7:0]    o_cap_exp,
  output logic [7:0]    o_cap_got
`endif
);

  localparam logic [CONSEC_W-1:0] LIMIT = CONSEC_W'(ERR_LIMIT);

  function automatic logic [ERR_CNT_W-1:0] sat_inc_err(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

  function automatic logic [BYTE_CNT_W-1:0] sat_inc_byte(input logic [BYTE_CNT_W-1:0] v);
    return (&v) ? v : v + BYTE_CNT_W'(1);
  endfunction

  function automatic logic [CONSEC_W-1:0] sat_inc_consec(input logic [CONSEC_W-1:0] v);
    return (v >= LIMIT) ? LIMIT : v + CONSEC_W'(1);
  endfunction

  chk_state_t              fsm_p1, fsm_nxt;
  logic                    err_p1;
  logic [ERR_CNT_W-1:0]    err_cnt_p1;
  logic [BYTE_CNT_W-1:0]   byte_cnt_p1;
  logic [CONSEC_W-1:0]     consec_p1;
  logic [CONSEC_W-1:0]     consec_inc;
  logic [7:0]              exp_byte;
  logic                    vld_p0;
  logic                    mis_p0;

  // stage p0: accept and compare
  assign vld_p0     = i_valid && !i_load && (fsm_p1 != ST_IDLE);
  assign mis_p0     = (i_byte != exp_byte);
  assign consec_inc = sat_inc_consec(consec_p1);

  rand_byte_model #(
    .RW(RW)
  ) u_model (
    .clk      (clk),
    .rst      (rst),
    .load     (i_load),
    .seed     (i_seed),
    .step     (vld_p0),
    .exp_byte (exp_byte)
  );

  always_comb begin
    fsm_nxt = fsm_p1;
    case (fsm_p1)
      ST_IDLE: begin
        if (i_load) fsm_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (i_load) begin
          fsm_nxt = ST_RUN;
        end else if (vld_p0 && mis_p0 && (consec_inc == LIMIT)) begin
          fsm_nxt = ST_FAIL;
        end
      end
      ST_FAIL: begin
        if (i_load) fsm_nxt = ST_RUN;
      end
      default: fsm_nxt = ST_IDLE;
    endcase
  end

  // stage p1: state, pulse and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_p1 <= ST_IDLE;
    end else begin
      fsm_p1 <= fsm_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_load) begin
      err_p1      <= 1'b0;
      err_cnt_p1  <= '0;
      byte_cnt_p1 <= '0;
      consec_p1   <= '0;
    end else begin
      err_p1 <= vld_p0 && mis_p0;
      if (vld_p0) begin
        byte_cnt_p1 <= sat_inc_byte(byte_cnt_p1);
        if (mis_p0) begin
          err_cnt_p1 <= sat_inc_err(err_cnt_p1);
          consec_p1  <= consec_inc;
        end else begin
          consec_p1  <= '0;
        end
      end
    end
  end

  assign o_err      = err_p1;
  assign o_err_cnt  = err_cnt_p1;
  assign o_byte_cnt = byte_cnt_p1;
  assign o_fail     = (fsm_p1 == ST_FAIL);
  assign o_running  = (fsm_p1 != ST_IDLE);

`ifdef RAND_CHK_ERR_CAPTURE_EN
  logic        cap_vld_p1;
  logic [31:0] cap_idx_p1;
  logic [7:0]  cap_exp_p1;
  logic [7:0]  cap_got_p1;
  logic        cap_take;

  assign cap_take = vld_p0 && mis_p0 && !cap_vld_p1;

  // stage p1: first-mismatch capture; data held while the flag is set
  always_ff @(posedge clk) begin
    if (rst || i_load) begin
      cap_vld_p1 <= 1'b0;
    end else if (cap_take) begin
      cap_vld_p1 <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (cap_take) begin
      cap_idx_p1 <= byte_cnt_p1;
      cap_exp_p1 <= exp_byte;
      cap_got_p1 <= i_byte;
    end
  end

  assign o_cap_valid = cap_vld_p1;
  assign o_cap_idx   = cap_idx_p1;
  assign o_cap_exp   = cap_exp_p1;
  assign o_cap_got   = cap_got_p1;
`endif

endmodule

// File: tb/tb_rand_byte_checker.sv
// Bench for rand_byte_checker: directed and random byte streams checked
// against a word-level reference of the expected sequence and counters.
module tb_rand_byte_checker;

  localparam int RW        = 32;
  localparam int ERR_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_load = 1'b0;
  logic [31:0] i_seed = '0;
  logic        i_valid = 1'b0;
  logic [7:0]  i_byte = '0;
  logic        o_err;
  logic [15:0] o_err_cnt;
  logic [31:0] o_byte_cnt;
  logic        o_fail;
  logic        o_running;
`ifdef RAND_CHK_ERR_CAPTURE_EN
  logic        o_cap_valid;
  logic [31:0] o_cap_idx;
  logic [7:0]  o_cap_exp;
  logic [7:0]  o_cap_got;
`endif

  always #5 clk = ~clk;

  rand_byte_checker #(
    .RW(RW),
    .ERR_LIMIT(ERR_LIMIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_load     (i_load),
    .i_seed     (i_seed),
    .i_valid    (i_valid),
    .i_byte     (i_byte),
    .o_err      (o_err),
    .o_err_cnt  (o_err_cnt),
    .o_byte_cnt (o_byte_cnt),
    .o_fail     (o_fail),
    .o_running  (o_running)
`ifdef RAND_CHK_ERR_CAPTURE_EN
    ,
    .o_cap_valid(o_cap_valid),
    .o_cap_idx  (o_cap_idx),
    .o_cap_exp  (o_cap_exp),
    .o_cap_got  (o_cap_got)
`endif
  );

  // Reference state
  logic [31:0] m_state = '0;
  logic        m_run = 1'b0;
  logic        m_fail = 1'b0;
  logic        m_err = 1'b0;
  int          m_consec = 0;
  logic [15:0] m_err_cnt = '0;
  logic [31:0] m_byte_cnt = '0;
`ifdef RAND_CHK_ERR_CAPTURE_EN
  logic        m_cap_v = 1'b0;
  logic [31:0] m_cap_idx = '0;
  logic [7:0]  m_cap_exp = '0;
  logic [7:0]  m_cap_got = '0;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // Word-level form of the sequence: shift left, fold the tap pattern in when the top bit leaves.
  function automatic logic [31:0] seq_next(input logic [31:0] s);
    logic [31:0] taps;
    taps = {4{8'hA3}};
    return {s[30:0], 1'b0} ^ (s[31] ? taps : 32'h0);
  endfunction

  task automatic model_edge(input logic rs, input logic ld, input logic [31:0] sd,
                            input logic vl, input logic [7:0] b);
    m_err = 1'b0;
    if (rs) begin
      m_state = '0; m_run = 1'b0; m_fail = 1'b0; m_consec = 0;
      m_err_cnt = '0; m_byte_cnt = '0;
`ifdef RAND_CHK_ERR_CAPTURE_EN
      m_cap_v = 1'b0;
`endif
    end else if (ld) begin
      m_state = sd; m_run = 1'b1; m_fail = 1'b0; m_consec = 0;
      m_err_cnt = '0; m_byte_cnt = '0;
`ifdef RAND_CHK_ERR_CAPTURE_EN
      m_cap_v = 1'b0;
`endif
    end else if (vl && m_run) begin
      if (b != m_state[7:0]) begin
        m_err = 1'b1;
`ifdef RAND_CHK_ERR_CAPTURE_EN
        if (!m_cap_v) begin
          m_cap_v = 1'b1; m_cap_idx = m_byte_cnt; m_cap_exp = m_state[7:0]; m_cap_got = b;
        end
`endif
        if (m_err_cnt != 16'hFFFF) m_err_cnt = m_err_cnt + 16'd1;
        if (m_consec < ERR_LIMIT) m_consec = m_consec + 1;
        if (m_consec == ERR_LIMIT) m_fail = 1'b1;
      end else begin
        m_consec = 0;
      end
      if (m_byte_cnt != 32'hFFFF_FFFF) m_byte_cnt = m_byte_cnt + 32'd1;
      m_state = seq_next(m_state);
    end
  endtask

  task automatic check_all(input string tag);
    n_assert++;
    assert (o_err === m_err) else begin
      n_fail++; $error("FAIL %s o_err got %0b want %0b", tag, o_err, m_err);
    end
    n_assert++;
    assert (o_err_cnt === m_err_cnt) else begin
      n_fail++; $error("FAIL %s o_err_cnt got %0d want %0d", tag, o_err_cnt, m_err_cnt);
    end
    n_assert++;
    assert (o_byte_cnt === m_byte_cnt) else begin
      n_fail++; $error("FAIL %s o_byte_cnt got %0d want %0d", tag, o_byte_cnt, m_byte_cnt);
    end
    n_assert++;
    assert (o_fail === m_fail) else begin
      n_fail++; $error("FAIL %s o_fail got %0b want %0b", tag, o_fail, m_fail);
    end
    n_assert++;
    assert (o_running === m_run) else begin
      n_fail++; $error("FAIL %s o_running got %0b want %0b", tag, o_running, m_run);
    end
`ifdef RAND_CHK_ERR_CAPTURE_EN
    n_assert++;
    assert (o_cap_valid === m_cap_v) else begin
      n_fail++; $error("FAIL %s o_cap_valid got %0b want %0b", tag, o_cap_valid, m_cap_v);
    end
    if (m_cap_v) begin
      n_assert++;
      assert ({o_cap_idx, o_cap_exp, o_cap_got} === {m_cap_idx, m_cap_exp, m_cap_got}) else begin
        n_fail++;
        $error("FAIL %s capture got idx=%0d exp=%h got=%h want idx=%0d exp=%h got=%h", tag,
               o_cap_idx, o_cap_exp, o_cap_got, m_cap_idx, m_cap_exp, m_cap_got);
      end
    end
`endif
  endtask

  task automatic drive(input string tag, input logic rs, input logic ld, input logic [31:0] sd,
                       input logic vl, input logic [7:0] b);
    rst = rs; i_load = ld; i_seed = sd; i_valid = vl; i_byte = b;
    @(posedge clk);
    model_edge(rs, ld, sd, vl, b);
    #1;
    check_all(tag);
  endtask

  task automatic send(input string tag, input logic [7:0] b);
    drive(tag, 1'b0, 1'b0, 32'h0, 1'b1, b);
  endtask

  task automatic idle(input string tag);
    drive(tag, 1'b0, 1'b0, 32'h0, 1'b0, 8'h00);
  endtask

  task automatic load(input string tag, input logic [31:0] sd);
    drive(tag, 1'b0, 1'b1, sd, 1'b0, 8'h00);
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_assert++;
    assert (got === want) else begin
      n_fail++; $error("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  initial begin
    logic [7:0] walk [9];
    logic [7:0] b;
    walk = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00};

    // Reset with load and valid also asserted: reset must win
    drive("reset0", 1'b1, 1'b1, 32'h1234_5678, 1'b1, 8'h78);
    drive("reset1", 1'b1, 1'b0, 32'h0, 1'b0, 8'h00);
    check_val("reset_running", {31'd0, o_running}, 32'd0);

    // Idle: bytes ignored
    for (int k = 0; k < 3; k++) send("idle_ignore", 8'($urandom));
    check_val("idle_bytes", o_byte_cnt, 32'd0);

    // Walking-one seed
    load("walk_load", 32'h0000_0001);
    foreach (walk[k]) send("walk", walk[k]);
    check_val("walk_bytes", o_byte_cnt, 32'd9);
    check_val("walk_errs", {16'd0, o_err_cnt}, 32'd0);

    // Top-bit seed: first step folds the taps in
    load("msb_load", 32'h8000_0000);
    send("msb_a", 8'h00);
    send("msb_b", 8'hA3);
    check_val("msb_ok_errs", {16'd0, o_err_cnt}, 32'd0);
    load("msb_reload", 32'h8000_0000);
    send("msb_c", 8'h00);
    send("msb_d", 8'hFF);
    check_val("msb_err_pulse", {31'd0, o_err}, 32'd1);
    check_val("msb_err_cnt", {16'd0, o_err_cnt}, 32'd1);

    // Three wrong then one right: no FAIL; then four wrong: FAIL
    load("lim_load", 32'h0000_0001);
    for (int k = 0; k < 3; k++) send("lim_bad3", m_state[7:0] ^ 8'hFF);
    send("lim_good", m_state[7:0]);
    check_val("lim_no_fail", {31'd0, o_fail}, 32'd0);
    for (int k = 0; k < 3; k++) send("lim_bad", m_state[7:0] ^ 8'hFF);
    check_val("lim_pre_fail", {31'd0, o_fail}, 32'd0);
    send("lim_bad4", m_state[7:0] ^ 8'hFF);
    check_val("lim_fail", {31'd0, o_fail}, 32'd1);
    for (int k = 0; k < 3; k++) send("fail_good", m_state[7:0]);
    check_val("fail_sticky", {31'd0, o_fail}, 32'd1);
    load("fail_reload", 32'h0000_0001);
    check_val("fail_cleared", {31'd0, o_fail}, 32'd0);

    // Load and valid together: the byte is discarded
    drive("ldvl", 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 8'h5A);
    for (int k = 0; k < 5; k++) send("ldvl_seq", m_state[7:0]);
    check_val("ldvl_bytes", o_byte_cnt, 32'd5);
    check_val("ldvl_errs", {16'd0, o_err_cnt}, 32'd0);

    // Random seeds, gaps and occasional corruption
    for (int t = 0; t < 4; t++) begin
      load("rnd_load", $urandom);
      for (int k = 0; k < 40; k++) begin
        int gap;
        gap = $urandom_range(0, 5);
        for (int g = 0; g < gap; g++) idle("rnd_gap");
        b = m_state[7:0];
        if ($urandom_range(0, 7) == 0) b = b ^ 8'($urandom_range(1, 255));
        send("rnd", b);
      end
    end

    // Reset mid-stream, with load and valid held high
    drive("mid_rst", 1'b1, 1'b1, $urandom, 1'b1, 8'($urandom));
    check_val("mid_rst_bytes", o_byte_cnt, 32'd0);
    for (int k = 0; k < 3; k++) send("post_rst", 8'($urandom));
    check_val("post_rst_running", {31'd0, o_running}, 32'd0);

    // All-zero seed: constant zero sequence
    load("zero_load", 32'h0);
    for (int k = 0; k < 5; k++) send("zero", 8'h00);
    send("zero_bad", 8'h01);
    check_val("zero_errs", {16'd0, o_err_cnt}, 32'd1);

`ifdef RAND_CHK_ERR_CAPTURE_EN
    load("cap_load", 32'h0000_0001);
    for (int k = 0; k < 10; k++) begin
      if (k == 5) send("cap", 8'h55);
      else if (k == 7) send("cap", 8'hEE);
      else send("cap", m_state[7:0]);
    end
    check_val("cap_idx", o_cap_idx, 32'd5);
    check_val("cap_got", {24'd0, o_cap_got}, 32'h55);
    check_val("cap_exp", {24'd0, o_cap_exp}, 32'h20);
    drive("cap_rst", 1'b1, 1'b0, 32'h0, 1'b0, 8'h00);
    check_val("cap_cleared", {31'd0, o_cap_valid}, 32'd0);
`endif

    rst = 1'b0; i_load = 1'b0; i_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
